// File: rtl/if_stage.sv
// Instruction fetch stage: issues one outstanding instruction-memory request at
// a time, delivers responses into the IF/ID register and uses a one-entry skid
// buffer when decode stalls. A redirect flushes the stage and refetches.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirectPC,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic        imemValid,
   input  logic [31:0] imemRdata,
   output logic [31:0] instOut,
   output logic [31:0] pcP,
   output logic [31:0] pcN,
   output logic        instValid
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH,
      WAIT,
      FULL,
      DROP
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] redirect_pc;
   logic [31:0] skid_inst;
   logic [31:0] skid_pc;
   logic        skid_valid;
   logic        load_from_mem;
   logic        load_to_skid;
   logic        load_from_skid;

   // Word-aligned views of the incoming addresses and the sequential successor.
   always_comb begin
      pc_plus4    = pc + 32'd4;
      redirect_pc = {redirectPC[31:2], 2'b00};
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= FETCH;
      else     state <= state_next;
   end

   // Next-state logic; redirect outranks stall and responses in every state.
   always_comb begin
      state_next = state;
      unique case (state)
         FETCH: state_next = redirect ? FETCH : WAIT;
         WAIT: begin
            if (redirect)                     state_next = imemValid ? FETCH : DROP;
            else if (imemValid && stall && instValid) state_next = FULL;
            else if (imemValid)               state_next = FETCH;
         end
         FULL: begin
            if (redirect || !stall) state_next = FETCH;
         end
         DROP: begin
            if (imemValid) state_next = FETCH;
         end
         default: state_next = FETCH;
      endcase
   end

   // FSM outputs: memory request and the load strobes for IF/ID and the skid buffer.
   always_comb begin
      imemReq        = (state == FETCH) && !redirect && !rst;
      imemAddr       = pc;
      load_from_mem  = 1'b0;
      load_to_skid   = 1'b0;
      load_from_skid = 1'b0;
      if (!redirect) begin
         if (state == WAIT && imemValid) begin
            if (stall && instValid) load_to_skid  = 1'b1;
            else                    load_from_mem = 1'b1;
         end
         if (state == FULL && skid_valid && !stall) load_from_skid = 1'b1;
      end
   end

   // Fetch PC: jumps to the redirect target or advances once per accepted response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                pc <= {RESET_PC[31:2], 2'b00};
      else if (redirect)                      pc <= redirect_pc;
      else if (load_from_mem || load_to_skid) pc <= pc_plus4;
   end

   // One-entry skid buffer holding a response that arrived while decode was stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_valid <= 1'b0;
         skid_inst  <= '0;
         skid_pc    <= '0;
      end else if (redirect) begin
         skid_valid <= 1'b0;
      end else if (load_to_skid) begin
         skid_valid <= 1'b1;
         skid_inst  <= imemRdata;
         skid_pc    <= pc;
      end else if (load_from_skid) begin
         skid_valid <= 1'b0;
      end
   end

   // IF/ID register: flush on redirect, load from memory or skid, bubble once consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instValid <= 1'b0;
         instOut   <= NOP;
         pcP       <= '0;
         pcN       <= '0;
      end else if (redirect) begin
         instValid <= 1'b0;
         instOut   <= NOP;
      end else if (load_from_mem) begin
         instValid <= 1'b1;
         instOut   <= imemRdata;
         pcP       <= pc;
         pcN       <= pc_plus4;
      end else if (load_from_skid) begin
         instValid <= 1'b1;
         instOut   <= skid_inst;
         pcP       <= skid_pc;
         pcN       <= skid_pc + 32'd4;
      end else if (!stall) begin
         instValid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a memory model with programmable latency, an in-order
// instruction-stream scoreboard, per-cycle rule checks and directed scenarios.
module tb_if_stage;

   localparam logic [31:0] RPC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirectPC = '0;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemValid = 1'b0;
   logic [31:0] imemRdata = '0;
   logic [31:0] instOut;
   logic [31:0] pcP;
   logic [31:0] pcN;
   logic        instValid;

   int vectors = 0;
   int errors  = 0;

   // memory model and stream scoreboard
   bit          mem_pend = 1'b0;
   logic [31:0] mem_addr = '0;
   int          mem_cnt  = 0;
   int          lat      = 1;
   logic [31:0] exp_pc   = RPC;
   bit          prev_hold = 1'b0;
   logic [31:0] prev_inst, prev_pcp, prev_pcn;
   int          consumed = 0;

   if_stage #(.RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
      .redirectPC(redirectPC), .imemReq(imemReq), .imemAddr(imemAddr),
      .imemValid(imemValid), .imemRdata(imemRdata), .instOut(instOut),
      .pcP(pcP), .pcN(pcN), .instValid(instValid)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      return a * 32'h0001_0001 + 32'h0050_0093;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs at negedge, check outputs, advance the models.
   task automatic cycle(input bit r, input bit st, input bit rd,
                        input logic [31:0] rpc, input bit spur);
      bit from_mem;
      @(negedge clk);
      rst = r; stall = st; redirect = rd; redirectPC = rpc;
      from_mem = !r && mem_pend && (mem_cnt == 0);
      if (from_mem) begin
         imemValid = 1'b1; imemRdata = word(mem_addr);
      end else if (spur) begin
         imemValid = 1'b1; imemRdata = 32'hDEAD_BEEF;
      end else begin
         imemValid = 1'b0; imemRdata = '0;
      end
      #1;
      if (r) begin
         chk1("rst_instValid", instValid, 1'b0);
         chk("rst_instOut", instOut, 32'h0000_0013);
         chk("rst_pcP", pcP, 32'h0);
         chk("rst_pcN", pcN, 32'h0);
         chk1("rst_imemReq", imemReq, 1'b0);
         chk("rst_imemAddr", imemAddr, RPC);
         mem_pend = 1'b0; exp_pc = RPC; prev_hold = 1'b0;
      end else begin
         chk("addr_align", {30'd0, imemAddr[1:0]}, 32'h0);
         if (instValid) begin
            chk("pcN_is_pcP_plus4", pcN, pcP + 32'd4);
            chk("inst_matches_pc", instOut, word(pcP));
         end
         if (prev_hold) begin
            chk1("hold_valid", instValid, 1'b1);
            chk("hold_inst", instOut, prev_inst);
            chk("hold_pcP", pcP, prev_pcp);
            chk("hold_pcN", pcN, prev_pcn);
         end
         prev_hold = instValid && st && !rd;
         prev_inst = instOut; prev_pcp = pcP; prev_pcn = pcN;
         if (instValid && !st && !rd) begin
            chk("stream_pc", pcP, exp_pc);
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         if (rd) exp_pc = {rpc[31:2], 2'b00};
         if (from_mem)      mem_pend = 1'b0;
         else if (mem_pend) mem_cnt--;
         if (imemReq) begin
            chk1("one_outstanding", mem_pend, 1'b0);
            mem_pend = 1'b1; mem_addr = imemAddr; mem_cnt = lat - 1;
         end
      end
   endtask

   initial begin
      logic [47:0] spat;
      int          start_consumed;
      spat = 48'h0F3_0C81_E6A5;

      cycle(1, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0);

      // reset release and first fetch with 1-cycle memory
      cycle(0, 0, 0, 0, 0);
      chk1("rel_req", imemReq, 1'b1);
      chk("rel_addr", imemAddr, RPC);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      chk1("first_valid", instValid, 1'b1);
      chk("first_inst", instOut, 32'h0050_0093);
      chk("first_pcP", pcP, 32'h0);
      chk("first_pcN", pcN, 32'h4);
      chk("first_next_addr", imemAddr, 32'h4);
      cycle(0, 0, 0, 0, 0);
      chk1("bubble_after_consume", instValid, 1'b0);

      // stall while a response arrives: skid buffer path
      cycle(0, 1, 0, 0, 0);
      chk("tput_pcP", pcP, 32'h4);
      cycle(0, 1, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
      chk1("full_no_req", imemReq, 1'b0);
      chk("full_hold_pcP", pcP, 32'h4);
      cycle(0, 1, 0, 0, 1);
      cycle(0, 0, 0, 0, 0);
      chk("unstall_old_pcP", pcP, 32'h4);
      cycle(0, 0, 0, 0, 0);
      chk("skid_pcP", pcP, 32'h8);
      chk("skid_inst", instOut, word(32'h8));
      chk("skid_next_addr", imemAddr, 32'hC);
      cycle(0, 0, 0, 0, 0);

      // redirect during a 3-cycle wait: DROP and discard
      lat = 3;
      cycle(0, 0, 0, 0, 0);
      chk("pre_redirect_pcP", pcP, 32'hC);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 1, 32'h0000_0100, 0);
      cycle(0, 0, 0, 0, 0);
      chk1("drop_valid", instValid, 1'b0);
      chk1("drop_no_req", imemReq, 1'b0);
      cycle(0, 0, 0, 0, 0);
      chk("redir_addr", imemAddr, 32'h100);
      chk1("redir_req", imemReq, 1'b1);
      lat = 1;
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      chk("redir_pcP", pcP, 32'h100);

      // redirect coinciding with a response, unaligned target
      cycle(0, 0, 1, 32'h0000_0203, 0);
      cycle(0, 0, 0, 0, 0);
      chk("same_cycle_addr", imemAddr, 32'h200);
      chk1("same_cycle_valid", instValid, 1'b0);
      chk("flush_nop", instOut, 32'h0000_0013);
      cycle(0, 0, 0, 0, 0);

      // redirect in FETCH to the top of the address space, then wrap
      cycle(0, 0, 1, 32'hFFFF_FFFC, 0);
      chk1("fetch_redir_no_req", imemReq, 1'b0);
      cycle(0, 0, 0, 0, 0);
      chk("top_addr", imemAddr, 32'hFFFF_FFFC);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      chk("wrap_pcP", pcP, 32'hFFFF_FFFC);
      chk("wrap_pcN", pcN, 32'h0);
      chk("wrap_addr", imemAddr, 32'h0);

      // asynchronous reset while in FULL
      cycle(0, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
      chk1("in_full_valid", instValid, 1'b1);
      chk1("in_full_no_req", imemReq, 1'b0);
      #1 rst = 1'b1;
      #1;
      chk1("async_instValid", instValid, 1'b0);
      chk("async_instOut", instOut, 32'h0000_0013);
      chk1("async_imemReq", imemReq, 1'b0);
      cycle(1, 0, 0, 0, 0);
      lat = 3;
      cycle(0, 0, 0, 0, 0);
      chk1("rel2_req", imemReq, 1'b1);
      chk("rel2_addr", imemAddr, RPC);

      // reset mid-WAIT, late response arrives in FETCH
      cycle(0, 0, 0, 0, 0);
      #1 rst = 1'b1;
      cycle(1, 0, 0, 0, 0);
      lat = 1;
      cycle(0, 0, 0, 0, 1);
      chk1("late_resp_req", imemReq, 1'b1);
      chk("late_resp_addr", imemAddr, RPC);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      chk1("after_late_valid", instValid, 1'b1);
      chk("after_late_inst", instOut, 32'h0050_0093);
      chk("after_late_pcP", pcP, 32'h0);

      // mixed stall pattern with redirects, including back-to-back in DROP
      lat = 2;
      start_consumed = consumed;
      for (int i = 0; i < 48; i++) begin
         if (i == 13)      cycle(0, spat[i], 1, 32'h0000_0040, 0);
         else if (i == 14) cycle(0, spat[i], 1, 32'h0000_0084, 0);
         else if (i == 30) cycle(0, spat[i], 1, 32'h0000_1000, 0);
         else              cycle(0, spat[i], 0, 0, 0);
      end
      chk1("loop_progress", (consumed - start_consumed) >= 3, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
